// File: rtl/sync_fifo_param_if.sv
// Handshake/status bundle for sync_fifo_param: producer/consumer side is the master,
// the FIFO itself is the slave. clk/rst stay plain module ports.
interface sync_fifo_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1280,
  parameter int LW    = $clog2(DEPTH + 1)
);
  logic             clr;
  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             full;
  logic             almost_full;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             almost_empty;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             underflow;

  modport master (
    output clr, wr_en, din, rd_en,
    input  full, almost_full, dout, empty, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, din, rd_en,
    output full, almost_full, dout, empty, almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with arbitrary depth, occupancy level, thresholds,
// synchronous flush and overflow/underflow pulses. Define SYNC_FIFO_FWFT_EN for first-word-fall-through.
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 1280,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4,
  parameter int LW        = $clog2(DEPTH + 1)
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave bus
);

  localparam int PW = $clog2(DEPTH);

  // Out-of-range thresholds collapse the flag to a constant
  localparam bit            AF_NEVER  = (AF_THRESH > DEPTH);
  localparam bit            AF_ALWAYS = (AF_THRESH <= 0);
  localparam bit            AE_NEVER  = (AE_THRESH < 0);
  localparam bit            AE_ALWAYS = (AE_THRESH >= DEPTH);
  localparam logic [LW-1:0] AF_T      = (AF_NEVER || AF_ALWAYS) ? '0 : LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_T      = (AE_NEVER || AE_ALWAYS) ? '0 : LW'(AE_THRESH);

  function automatic logic afOf(input logic [LW-1:0] lvl);
    if (AF_NEVER)       return 1'b0;
    else if (AF_ALWAYS) return 1'b1;
    else                return (lvl >= AF_T);
  endfunction

  function automatic logic aeOf(input logic [LW-1:0] lvl);
    if (AE_NEVER)       return 1'b0;
    else if (AE_ALWAYS) return 1'b1;
    else                return (lvl <= AE_T);
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             full_q, empty_q, empty_d, af_q, ae_q;
  logic             ovf_q, udf_q;
  logic [WIDTH-1:0] dout_q;
  logic             wrAcc, rdAcc, popMem;

`ifdef SYNC_FIFO_FWFT_EN
  logic             outValid_q, outValid_d;
  logic [LW-1:0]    memCount_q, memCount_d;

  // Output register is refilled from memory whenever it is free or being popped
  always_comb begin
    rdAcc      = bus.rd_en & outValid_q & ~bus.clr;
    wrAcc      = bus.wr_en & (~full_q | rdAcc) & ~bus.clr;
    popMem     = (~outValid_q | rdAcc) & (memCount_q != '0) & ~bus.clr;
    outValid_d = outValid_q;
    memCount_d = memCount_q + LW'(wrAcc) - LW'(popMem);
    if (bus.clr) begin
      outValid_d = 1'b0;
      memCount_d = '0;
    end else if (popMem) begin
      outValid_d = 1'b1;
    end else if (rdAcc) begin
      outValid_d = 1'b0;
    end
    empty_d = ~outValid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid_q <= 1'b0;
      memCount_q <= '0;
    end else begin
      outValid_q <= outValid_d;
      memCount_q <= memCount_d;
    end
  end
`else
  always_comb begin
    rdAcc   = bus.rd_en & ~empty_q & ~bus.clr;
    wrAcc   = bus.wr_en & (~full_q | rdAcc) & ~bus.clr;
    popMem  = rdAcc;
    empty_d = (level_d == '0);
  end
`endif

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (bus.clr) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      level_d = '0;
    end else begin
      if (wrAcc) wrPtr_d = (wrPtr_q == PW'(DEPTH - 1)) ? '0 : wrPtr_q + 1'b1;
      if (popMem) rdPtr_d = (rdPtr_q == PW'(DEPTH - 1)) ? '0 : rdPtr_q + 1'b1;
      case ({wrAcc, rdAcc})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wrAcc) mem[wrPtr_q] <= bus.din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      empty_q <= empty_d;
      af_q    <= afOf(level_d);
      ae_q    <= aeOf(level_d);
      ovf_q   <= bus.wr_en & ~wrAcc & ~bus.clr;
      udf_q   <= bus.rd_en & ~rdAcc & ~bus.clr;
      if (popMem) dout_q <= mem[rdPtr_q];
    end
  end

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.level        = level_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
  assign bus.dout         = dout_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: a queue-based reference model predicts flags and
// read data; a monitor process checks each predicted dout word when it falls due.
module tb_sync_fifo_param;

  localparam int WIDTH   = 8;
  localparam int DEPTH_A = 5;
  localparam int AF_A    = 4;
  localparam int AE_A    = 1;
  localparam int DEPTH_B = 1280;

  typedef struct {
    int         due;
    logic [7:0] data;
  } expItem_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH_A)) busA ();
  sync_fifo_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH_B)) busB ();

  sync_fifo_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH_A), .AF_THRESH(AF_A), .AE_THRESH(AE_A)
  ) dutA (
    .clk(clk), .rst(rst), .bus(busA)
  );

  sync_fifo_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH_B)
  ) dutB (
    .clk(clk), .rst(rst), .bus(busB)
  );

  always #5 clk = ~clk;

  logic [7:0] modelQ[$];
  expItem_t   expQ[$];
  expItem_t   monItem;
  logic [7:0] holdVal = 8'h00;
  bit         expOvf = 1'b0;
  bit         expUdf = 1'b0;
  bit         monitorOn = 1'b0;
  int         cycleCount = 0;
  int         compared = 0;
  int         mismatched = 0;

  always @(posedge clk) cycleCount++;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cycleCount);
    end
  endtask

  task automatic checkFlags();
    int n;
    n = modelQ.size();
    checkOutput("level", 32'(busA.level), n);
    checkOutput("full", 32'(busA.full), 32'(n == DEPTH_A));
    checkOutput("empty", 32'(busA.empty), 32'(n == 0));
    checkOutput("almost_full", 32'(busA.almost_full), 32'(n >= AF_A));
    checkOutput("almost_empty", 32'(busA.almost_empty), 32'(n <= AE_A));
    checkOutput("overflow", 32'(busA.overflow), 32'(expOvf));
    checkOutput("underflow", 32'(busA.underflow), 32'(expUdf));
  endtask

  // One clock of stimulus on FIFO A; the model predicts acceptance from occupancy alone
  task automatic applyStimulus(input bit c, input bit w, input bit r, input logic [7:0] d);
    bit       rdOk, wrOk;
    expItem_t item;
    @(negedge clk);
    busA.clr   = c;
    busA.wr_en = w;
    busA.rd_en = r;
    busA.din   = d;
    if (c) begin
      modelQ.delete();
      expOvf = 1'b0;
      expUdf = 1'b0;
    end else begin
      rdOk = r && (modelQ.size() > 0);
      wrOk = w && ((modelQ.size() < DEPTH_A) || rdOk);
      if (rdOk) begin
        item.due  = cycleCount + 1;
        item.data = modelQ.pop_front();
        expQ.push_back(item);
      end
      if (wrOk) modelQ.push_back(d);
      expOvf = w && !wrOk;
      expUdf = r && !rdOk;
    end
    @(posedge clk);
    #1;
    checkFlags();
  endtask

  task automatic clearModel();
    modelQ.delete();
    expQ.delete();
    holdVal = 8'h00;
    expOvf  = 1'b0;
    expUdf  = 1'b0;
  endtask

  task automatic idleInputs();
    busA.clr = 1'b0; busA.wr_en = 1'b0; busA.rd_en = 1'b0; busA.din = '0;
    busB.clr = 1'b0; busB.wr_en = 1'b0; busB.rd_en = 1'b0; busB.din = '0;
  endtask

  task automatic doReset(input int cycles);
    idleInputs();
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clearModel();
  endtask

  // Reset asserted between edges must clear state without waiting for a clock
  task automatic asyncReset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_level", 32'(busA.level), 0);
    checkOutput("async_empty", 32'(busA.empty), 1);
    checkOutput("async_dout", 32'(busA.dout), 0);
    idleInputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clearModel();
  endtask

  // Read data monitor: a due word must appear on dout, otherwise dout must hold
  always @(posedge clk) begin
    #1;
    if (monitorOn && !rst) begin
      if (expQ.size() > 0 && expQ[0].due <= cycleCount) begin
        monItem = expQ.pop_front();
        checkOutput("dout", 32'(busA.dout), 32'(monItem.data));
        holdVal = monItem.data;
      end else begin
        checkOutput("dout_hold", 32'(busA.dout), 32'(holdVal));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idleInputs();
    doReset(3);
    checkFlags();
    checkOutput("reset_dout", 32'(busA.dout), 0);
    checkOutput("reset_B_level", 32'(busB.level), 0);
    checkOutput("reset_B_almost_empty", 32'(busB.almost_empty), 1);

`ifdef SYNC_FIFO_FWFT_EN
    // First-word-fall-through: head word shows up two edges after the write, no rd_en
    @(negedge clk);
    busA.wr_en = 1'b1;
    busA.din   = 8'hA5;
    @(negedge clk);
    busA.wr_en = 1'b0;
    checkOutput("fwft_empty_1cyc", 32'(busA.empty), 1);
    @(negedge clk);
    checkOutput("fwft_dout", 32'(busA.dout), 32'h A5);
    checkOutput("fwft_empty", 32'(busA.empty), 0);
    checkOutput("fwft_level", 32'(busA.level), 1);
    busA.rd_en = 1'b1;
    @(negedge clk);
    busA.rd_en = 1'b0;
    checkOutput("fwft_pop_empty", 32'(busA.empty), 1);
    checkOutput("fwft_pop_level", 32'(busA.level), 0);
`else
    monitorOn = 1'b1;

    // Fill, overflow, drain, underflow
    for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'h11 * i));
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h66);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

    // Pointer wrap: 3 in, 3 out, then 7 in (two rejected)
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'hA0 + i));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'hB0 + i));

    // Simultaneous read+write on full, then on empty
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hC1);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'hD1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);

    // Flush wins over simultaneous write and read
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'(8'hE0 + i));
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hEE);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h5A);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);

    // Randomised traffic: fill-biased phase, async reset, drain-biased phase
    for (int i = 0; i < 600; i++) begin
      if (i == 300) asyncReset();
      applyStimulus($urandom_range(0, 49) == 0,
                    $urandom_range(0, 99) < ((i < 300) ? 65 : 40),
                    $urandom_range(0, 99) < ((i < 300) ? 40 : 65),
                    8'($urandom));
    end
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("scoreboard_drained", expQ.size(), 0);

    // Deep FIFO: almost_full boundary at 1276, then flush with a concurrent write
    for (int i = 0; i < 1276; i++) begin
      @(negedge clk);
      if (i == 1275) begin
        checkOutput("B_level_1275", 32'(busB.level), 1275);
        checkOutput("B_af_1275", 32'(busB.almost_full), 0);
      end
      busB.wr_en = 1'b1;
      busB.din   = 8'(i);
    end
    @(negedge clk);
    busB.wr_en = 1'b0;
    checkOutput("B_level_1276", 32'(busB.level), 1276);
    checkOutput("B_af_1276", 32'(busB.almost_full), 1);
    checkOutput("B_ae_1276", 32'(busB.almost_empty), 0);
    checkOutput("B_full_1276", 32'(busB.full), 0);
    busB.clr   = 1'b1;
    busB.wr_en = 1'b1;
    busB.din   = 8'hEE;
    @(negedge clk);
    busB.clr   = 1'b0;
    busB.wr_en = 1'b0;
    checkOutput("B_clr_level", 32'(busB.level), 0);
    checkOutput("B_clr_empty", 32'(busB.empty), 1);
    checkOutput("B_clr_overflow", 32'(busB.overflow), 0);
    checkOutput("B_clr_af", 32'(busB.almost_full), 0);
    busB.wr_en = 1'b1;
    busB.din   = 8'h3C;
    @(negedge clk);
    busB.wr_en = 1'b0;
    busB.rd_en = 1'b1;
    @(negedge clk);
    busB.rd_en = 1'b0;
    checkOutput("B_after_clr_dout", 32'(busB.dout), 32'h3C);
    checkOutput("B_after_clr_level", 32'(busB.level), 0);
`endif

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
